conv_maxpool2x2: RTL and testbench
==================================

Name: conv_maxpool2x2

Overview:
- Downstream stage of the convolution engine.
- Consumes the convolution result pixels as a row-major stream and applies 2x2, stride-2 max-pooling.
- Emits the pooled stream with a valid/ready handshake to the next stage, which is a result file writer or the next layer.
- A one-row line buffer holds the horizontal pair maxima of each even row, so the input is never stored as a whole frame.

Parameters:
- DATA_W, 8, pixel width; values are unsigned.
- ROW_W, 12, input pixels per row; must be even.
- ROW_N, 12, input rows per frame; must be even.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse that arms the block for one frame.
- in_valid  in  1  in_data is valid.
- in_data  in  DATA_W  result pixel from the convolution stage.
- in_ready  out  1  block accepts in_data this cycle.
- out_valid  out  1  out_data holds a pooled pixel.
- out_data  out  DATA_W  pooled pixel, max of a 2x2 window.
- out_ready  in  1  downstream accepts out_data.
- done  out  1  one-cycle pulse when the last pooled pixel is transferred.

Behaviour:
Reset and transfer rules
- Reset value of every output: in_ready=0, out_valid=0, out_data=0, done=0.
- Reset also clears the FSM, all counters, the pair register and the valid flag.
- rst asserted mid-frame discards the frame in progress; no partial output is emitted afterwards.
- An input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.

FSM states
- IDLE: in_ready=0. start moves to EVEN and clears col_cnt and row_cnt.
- EVEN (row_cnt even): in_ready=1.
  - First pixel of a pair (col_cnt even): store it in pair_reg.
  - Second pixel: write max(pair_reg, in_data) to line_buf[col_cnt>>1].
- ODD (row_cnt odd): in_ready = !(out_valid && !out_ready).
  - First pixel of a pair: store it in pair_reg.
  - Second pixel: load max(pair_reg, in_data, line_buf[col_cnt>>1]) into the output register and set out_valid on the next edge. Latency is 1 cycle from the accepting edge.
- DRAIN: entered after the last input pixel is accepted. in_ready=0. Wait for the final output transfer, pulse done in that cycle, then go to IDLE.

Counters
- col_cnt counts 0..ROW_W-1 and wraps to 0 at ROW_W-1. The same transfer toggles the state EVEN<->ODD and increments row_cnt.
- The last input pixel is the one at row_cnt=ROW_N-1 and col_cnt=ROW_W-1. Accepting it moves the FSM to DRAIN instead of EVEN.

Output register
- Single entry; out_data holds its value while out_valid && !out_ready.
- A transfer in the same cycle as a new load refills the register, which gives full throughput.
- The clear condition is a transfer with no new load.

Arithmetic and buffer
- All compares are unsigned, full DATA_W; there is no width growth.
- Ties may select either operand, since the values are equal.
- line_buf has ROW_W/2 entries of DATA_W bits. It is read and written with the same index, and the read occurs in ODD rows only, so there is no read/write hazard.

Other rules
- start while not in IDLE is ignored.
- in_valid while in IDLE is ignored, because in_ready=0.
- Output order is row-major over the pooled (ROW_N/2) x (ROW_W/2) grid.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, EVEN, ODD, DRAIN; 2 bits).
  - Counter width function (clog2).
  - Default DATA_W, ROW_W and ROW_N constants, matching the convolution output dimensions.
- One natural sub-module, pool_line_buffer: synchronous-write, combinational-read register array of ROW_W/2 x DATA_W, with wr_en, wr_addr, wr_data and rd_addr.
- The FSM, counters, comparators and output register stay in the top module.

Test Plan:
1. Reset then idle: hold rst 2 cycles, then in_valid=1 without start. Required: in_ready=0, out_valid=0, done=0 throughout.
2. Basic frame with ROW_W=4, ROW_N=2, rows [1,5,2,3] and [4,0,9,7], out_ready=1. Required: outputs 5 then 9, each 1 cycle after its pair completes. done pulses with the transfer of 9; the FSM returns to IDLE.
3. Full 12x12 frame, in_data = row*12+col, out_ready=1. Required: 36 outputs equal to (2r+1)*12+(2c+1) for r,c in 0..5; exactly one done pulse.
4. Backpressure: repeat scenario 3 with out_ready low for 5 cycles whenever out_valid rises. Required:
   - out_data is stable while stalled.
   - in_ready=0 during the stall in ODD rows.
   - No output is lost or duplicated; the sequence is identical to scenario 3.
5. Unsigned boundary: a 2x2 window {255,0,128,254}. Required: output 255. A window of all zeros gives output 0.
6. Reset mid-frame: assert rst after 20 input pixels of a 12x12 frame, then start a new frame. Required: no output from the aborted frame; the new frame produces the full 36 correct outputs and one done pulse.

Source files
------------

// File: rtl/conv_maxpool2x2_pkg.sv
// conv_maxpool2x2_pkg: shared state encoding, counter sizing and default frame geometry
package conv_maxpool2x2_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ROW_W  = 12;
    localparam int DEF_ROW_N  = 12;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EVEN,
        S_ODD,
        S_DRAIN
    } pool_state_e;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_maxpool2x2_pool_line_buffer.sv
// pool_line_buffer: one row of horizontal pair maxima, synchronous write and combinational read
module pool_line_buffer
    import conv_maxpool2x2_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_ROW_W / 2,
    parameter int AW     = cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/conv_maxpool2x2.sv
// conv_maxpool2x2: streaming 2x2 stride-2 max-pool over a row-major pixel stream
module conv_maxpool2x2
    import conv_maxpool2x2_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ROW_W  = DEF_ROW_W,
    parameter int ROW_N  = DEF_ROW_N
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              done
);

    localparam int CW = cnt_w(ROW_W);
    localparam int RW = cnt_w(ROW_N);
    localparam int AW = cnt_w(ROW_W / 2);

    pool_state_e       state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [DATA_W-1:0] pair_q, pair_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] lb_rd, pair_max, win_max;
    logic [AW-1:0]     lb_addr;
    logic              in_fire, out_fire, second, col_last, frame_last, lb_we, load;

    pool_line_buffer #(.DATA_W(DATA_W), .DEPTH(ROW_W / 2), .AW(AW)) u_line_buf (
        .clk     (clk),
        .wr_en   (lb_we),
        .wr_addr (lb_addr),
        .wr_data (pair_max),
        .rd_addr (lb_addr),
        .rd_data (lb_rd)
    );

    // odd rows stall input while the single output slot is blocked
    assign in_ready  = (state_q == S_EVEN) || (state_q == S_ODD && !(out_valid_q && !out_ready));
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign done      = (state_q == S_DRAIN) && out_fire;

    always_comb begin
        in_fire     = in_valid && in_ready;
        out_fire    = out_valid_q && out_ready;
        second      = col_q[0];
        col_last    = col_q == CW'(ROW_W - 1);
        frame_last  = col_last && (row_q == RW'(ROW_N - 1));
        lb_addr     = AW'(col_q >> 1);
        pair_max    = (in_data > pair_q) ? in_data : pair_q;
        win_max     = (lb_rd > pair_max) ? lb_rd : pair_max;
        lb_we       = in_fire && second && (state_q == S_EVEN);
        load        = in_fire && second && (state_q == S_ODD);
        pair_d      = (in_fire && !second) ? in_data : pair_q;
        out_data_d  = load ? win_max : out_data_q;
        out_valid_d = load || (out_valid_q && !out_ready);
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        if (state_q == S_IDLE && start) begin
            state_d = S_EVEN;
            col_d   = '0;
            row_d   = '0;
        end else if (in_fire) begin
            col_d = col_last ? '0 : col_q + 1'b1;
            if (col_last) begin
                row_d   = row_q + 1'b1;
                state_d = frame_last ? S_DRAIN : (state_q == S_EVEN) ? S_ODD : S_EVEN;
            end
        end else if (state_q == S_DRAIN && out_fire) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            pair_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            pair_q      <= pair_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_conv_maxpool2x2.sv
// tb_conv_maxpool2x2: random and directed frames checked against a plain-array pooling model
module tb_conv_maxpool2x2;

    localparam int W = 12;
    localparam int N = 12;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, in_valid, in_ready, out_valid, out_ready, done;
    logic [7:0] in_data, out_data;
    logic       s_start, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_done;
    logic [7:0] s_in_data, s_out_data;

    int total = 0;
    int bad   = 0;

    logic [7:0] frame [N*W];
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    conv_maxpool2x2 #(.DATA_W(8), .ROW_W(W), .ROW_N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .done(done)
    );

    conv_maxpool2x2 #(.DATA_W(8), .ROW_W(4), .ROW_N(2)) dut_s (
        .clk(clk), .rst(rst), .start(s_start), .in_valid(s_in_valid), .in_data(s_in_data),
        .in_ready(s_in_ready), .out_valid(s_out_valid), .out_data(s_out_data),
        .out_ready(s_out_ready), .done(s_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic build_ref();
        exp_q.delete();
        for (int r = 0; r < N / 2; r++)
            for (int c = 0; c < W / 2; c++) begin
                int m = 0;
                for (int dr = 0; dr < 2; dr++)
                    for (int dc = 0; dc < 2; dc++)
                        if (int'(frame[(2*r+dr)*W + 2*c+dc]) > m) m = int'(frame[(2*r+dr)*W + 2*c+dc]);
                exp_q.push_back(8'(m));
            end
    endtask

    // bp holds out_ready low for 5 cycles after each output appears; abort_after>0 stops feeding early
    task automatic run_frame(input bit bp, input int abort_after);
        int idx = 0, hold = 5, cyc = 0, dones = 0;
        bit fin = 0, stall, prev_stall = 0;
        logic [7:0] prev_data = '0;
        build_ref();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (!fin) begin
            in_valid  = (idx < N*W) && ($urandom_range(0, 3) != 0);
            in_data   = frame[(idx < N*W) ? idx : 0];
            out_ready = !bp || hold == 0;
            @(negedge clk);
            stall = out_valid && !out_ready;
            if (stall && prev_stall) check("hold_data", out_data, prev_data);
            if (stall && idx < N*W && (idx / W) % 2 == 1) check("odd_stall_in_ready", in_ready, 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("extra_out", 1, 0);
                else check("out_data", out_data, exp_q.pop_front());
                check("done_timing", done, exp_q.size() == 0);
                fin  = exp_q.size() == 0;
                hold = 5;
            end else begin
                check("done_spurious", done, 0);
                if (out_valid && hold > 0) hold--;
            end
            if (done) dones++;
            if (in_valid && in_ready) idx++;
            prev_stall = stall;
            prev_data  = out_data;
            if (abort_after > 0 && idx >= abort_after) break;
            cyc++;
            if (cyc > 5000) begin
                check("frame_timeout", cyc, 0);
                fin = 1;
            end
            if (!fin) @(posedge clk);
            if (!fin) #1;
        end
        @(posedge clk); #1 in_valid = 1'b0;
        if (abort_after == 0) begin
            check("done_count", dones, 1);
            check("exp_left", exp_q.size(), 0);
            out_ready = 1'b1;
            @(negedge clk);
            check("idle_in_ready", in_ready, 0);
            check("idle_out_valid", out_valid, 0);
        end
    endtask

    task automatic small_frame(input logic [63:0] px, input logic [7:0] e0, input logic [7:0] e1);
        @(posedge clk); #1 s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            s_in_valid = 1'b1;
            s_in_data  = px[8*k +: 8];
            @(negedge clk);
            check("s_in_ready", s_in_ready, 1);
            @(posedge clk); #1;
            s_in_valid = 1'b0;
            check("s_out_valid", s_out_valid, k == 5 || k == 7);
            if (k == 5) check("s_out0", s_out_data, e0);
            if (k == 7) check("s_out1", s_out_data, e1);
            check("s_done", s_done, k == 7);
        end
        @(posedge clk); #1;
        check("s_idle_in_ready", s_in_ready, 0);
        check("s_idle_out_valid", s_out_valid, 0);
        check("s_idle_done", s_done, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0; in_valid = 1'b1; in_data = 8'd77; out_ready = 1'b1;
        s_start = 1'b0; s_in_valid = 1'b1; s_in_data = 8'd33; s_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("rst_in_ready", in_ready, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_out_data", out_data, 0);
            check("rst_done", done, 0);
            check("rst_s_in_ready", s_in_ready, 0);
            check("rst_s_out_valid", s_out_valid, 0);
        end
        @(posedge clk); #1 in_valid = 1'b0; s_in_valid = 1'b0;

        small_frame({8'd7, 8'd9, 8'd0, 8'd4, 8'd3, 8'd2, 8'd5, 8'd1}, 8'd5, 8'd9);
        small_frame({8'd0, 8'd0, 8'd254, 8'd128, 8'd0, 8'd0, 8'd0, 8'd255}, 8'd255, 8'd0);

        for (int i = 0; i < N*W; i++) frame[i] = 8'(i);
        run_frame(1'b0, 0);
        run_frame(1'b1, 0);
        for (int i = 0; i < N*W; i++) frame[i] = 8'($urandom);
        run_frame(1'b1, 0);

        run_frame(1'b0, 20);
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) begin
            out_ready = 1'($urandom);
            @(negedge clk);
            check("abort_out_valid", out_valid, 0);
            check("abort_done", done, 0);
            @(posedge clk); #1;
        end
        for (int i = 0; i < N*W; i++) frame[i] = 8'($urandom);
        run_frame(1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
